// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath and pipe_hazard_ctrl.
// Latency: n/a (wires only). Backpressure: carried as enables/flushes from slave to master.
// Ports: master = datapath (drives stage status, receives controls), slave = controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // stage status from the datapath
  logic [4:0]       id_rs, id_rt;
  logic             id_use_rs, id_use_rt;
  logic [4:0]       ex_rs, ex_rt, ex_td;
  logic             ex_WREG, ex_mem_read, ex_branch_taken;
  logic [4:0]       me_td;
  logic             me_WREG, me_mem_access;
  logic             dmem_ready;
  logic [4:0]       wb_td;
  logic             wb_WREG;
  // controls back to the datapath
  logic             pc_en, ifid_en, idex_en, exme_en, mewb_en;
  logic             ifid_flush, idex_flush, mewb_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             dmem_req;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_td,
           ex_WREG, ex_mem_read, ex_branch_taken, me_td, me_WREG,
           me_mem_access, dmem_ready, wb_td, wb_WREG,
    input  pc_en, ifid_en, idex_en, exme_en, mewb_en, ifid_flush,
           idex_flush, mewb_flush, fwd_a, fwd_b, dmem_req, mem_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_td,
           ex_WREG, ex_mem_read, ex_branch_taken, me_td, me_WREG,
           me_mem_access, dmem_ready, wb_td, wb_WREG,
    output pc_en, ifid_en, idex_en, exme_en, mewb_en, ifid_flush,
           idex_flush, mewb_flush, fwd_a, fwd_b, dmem_req, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: load-use stall, branch flush, dmem wait with timeout, EX forwarding.
// Latency: enables/flushes/forwarding combinational; mem_err and stall_cnt update on the edge.
// Backpressure: dmem not ready freezes PC..EX_ME and bubbles WB, forced release after MEM_TIMEOUT.
// Ports: clk, rst (async, active-high), hz (slave side of pipe_hazard_ctrl_if).
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WC_W = $clog2(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;

  logic timeout, release_c, mem_stall, lu;
  logic pc_en, ifid_en, idex_en, exme_en, mewb_en;
  logic ifid_flush, idex_flush, mewb_flush;
  logic [1:0] fwd_a, fwd_b;

  // Forced release only exists while already waiting; in RUN only dmem_ready releases.
  assign timeout   = (state_q == MEM_WAIT) && (wait_q == WC_W'(MEM_TIMEOUT - 1));
  assign release_c = hz.dmem_ready | timeout;
  assign mem_stall = hz.me_mem_access & ~release_c;

  assign lu = hz.ex_mem_read & hz.ex_WREG & (hz.ex_td != 5'd0) &
              ((hz.id_use_rs & (hz.id_rs == hz.ex_td)) |
               (hz.id_use_rt & (hz.id_rt == hz.ex_td)));

  // Next state for the memory-wait FSM
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (release_c) begin
          state_d = RUN;
          wait_d  = '0;
          // a ready on the timeout cycle is an ordinary completion
          if (!hz.dmem_ready) err_d = 1'b1;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Stall/flush priority: memory wait > taken branch > load-use
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exme_en    = 1'b1;
    mewb_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mewb_flush = 1'b0;
    if (mem_stall) begin
      // branch/load-use inputs are held, so they are resolved after release
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exme_en    = 1'b0;
      mewb_flush = 1'b1;
    end else if (hz.ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Forwarding: the younger result (ME) wins over WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hz.me_WREG && hz.me_td != 5'd0 && hz.me_td == hz.ex_rs)      fwd_a = 2'b01;
    else if (hz.wb_WREG && hz.wb_td != 5'd0 && hz.wb_td == hz.ex_rs) fwd_a = 2'b10;
    if (hz.me_WREG && hz.me_td != 5'd0 && hz.me_td == hz.ex_rt)      fwd_b = 2'b01;
    else if (hz.wb_WREG && hz.wb_td != 5'd0 && hz.wb_td == hz.ex_rt) fwd_b = 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (!pc_en && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.idex_en    = idex_en;
  assign hz.exme_en    = exme_en;
  assign hz.mewb_en    = mewb_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_flush = idex_flush;
  assign hz.mewb_flush = mewb_flush;
  assign hz.fwd_a      = fwd_a;
  assign hz.fwd_b      = fwd_b;
  assign hz.dmem_req   = hz.me_mem_access;
  assign hz.mem_err    = err_q;
  assign hz.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_wait: cycles this ME access has already been held (0 = not waiting).
  int m_wait = 0;
  int m_err  = 0;
  int m_cnt  = 0;

  typedef struct packed {
    logic pc, ifid, idex, exme, mewb;
    logic fi, fx, fw;
    logic [1:0] fa, fb;
    logic req;
  } exp_t;

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (hz.me_WREG && hz.me_td != 0 && hz.me_td == src) return 2'b01;
    if (hz.wb_WREG && hz.wb_td != 0 && hz.wb_td == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic model_release();
    // an access can be held at most TO-1 cycles; the TO-th cycle always advances
    return hz.dmem_ready || (m_wait != 0 && m_wait == TO - 1);
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    logic stall, luh;
    stall = hz.me_mem_access && !model_release();
    luh = hz.ex_mem_read && hz.ex_WREG && hz.ex_td != 0 &&
          ((hz.id_use_rs && hz.id_rs == hz.ex_td) || (hz.id_use_rt && hz.id_rt == hz.ex_td));
    e = '0;
    {e.pc, e.ifid, e.idex, e.exme, e.mewb} = 5'b11111;
    if (stall) begin
      {e.pc, e.ifid, e.idex, e.exme} = 4'b0000;
      e.fw = 1'b1;
    end else if (hz.ex_branch_taken) begin
      e.fi = 1'b1;
      e.fx = 1'b1;
    end else if (luh) begin
      e.pc = 1'b0;
      e.ifid = 1'b0;
      e.fx = 1'b1;
    end
    e.fa  = fwd_of(hz.ex_rs);
    e.fb  = fwd_of(hz.ex_rt);
    e.req = hz.me_mem_access;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    exp_t e;
    if (rst) begin
      m_wait <= 0;
      m_err  <= 0;
      m_cnt  <= 0;
    end else begin
      e = model_exp();
      if (!e.pc) m_cnt <= (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
      if (m_wait == 0) begin
        if (!e.pc && hz.me_mem_access && !hz.dmem_ready) m_wait <= 1;
      end else if (model_release()) begin
        m_wait <= 0;
        if (!hz.dmem_ready) m_err <= 1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin : cmp
    exp_t e;
    e = model_exp();
    chk("pc_en",      hz.pc_en,      e.pc);
    chk("ifid_en",    hz.ifid_en,    e.ifid);
    chk("idex_en",    hz.idex_en,    e.idex);
    chk("exme_en",    hz.exme_en,    e.exme);
    chk("mewb_en",    hz.mewb_en,    e.mewb);
    chk("ifid_flush", hz.ifid_flush, e.fi);
    chk("idex_flush", hz.idex_flush, e.fx);
    chk("mewb_flush", hz.mewb_flush, e.fw);
    chk("fwd_a",      hz.fwd_a,      e.fa);
    chk("fwd_b",      hz.fwd_b,      e.fb);
    chk("dmem_req",   hz.dmem_req,   e.req);
    chk("mem_err",    hz.mem_err,    m_err);
    chk("stall_cnt",  hz.stall_cnt,  m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    hz.id_rs = 0; hz.id_rt = 0; hz.id_use_rs = 0; hz.id_use_rt = 0;
    hz.ex_rs = 0; hz.ex_rt = 0; hz.ex_td = 0;
    hz.ex_WREG = 0; hz.ex_mem_read = 0; hz.ex_branch_taken = 0;
    hz.me_td = 0; hz.me_WREG = 0; hz.me_mem_access = 0; hz.dmem_ready = 0;
    hz.wb_td = 0; hz.wb_WREG = 0;
  endtask

  // inputs change 1 time unit after the edge, literal checks 1 unit later
  task automatic next_cycle();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic set_lu();
    hz.ex_td = 5; hz.ex_mem_read = 1; hz.ex_WREG = 1;
    hz.id_rs = 5; hz.id_use_rs = 1;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall_cnt", hz.stall_cnt, 0);
    chk("rst_mem_err",   hz.mem_err,   0);
    chk("rst_pc_en",     hz.pc_en,     1);
    next_cycle();
    rst = 1'b0;

    // load-use: one bubble
    next_cycle(); set_lu(); #1;
    chk("lu_pc_en",      hz.pc_en,      0);
    chk("lu_ifid_en",    hz.ifid_en,    0);
    chk("lu_idex_flush", hz.idex_flush, 1);
    chk("lu_idex_en",    hz.idex_en,    1);
    next_cycle(); hz.me_td = 5; hz.me_WREG = 1; hz.id_rs = 5; hz.id_use_rs = 1; #1;
    chk("lu_after_pc_en", hz.pc_en,     1);
    chk("lu_stall_cnt",   hz.stall_cnt, 1);
    // load targeting r0 never stalls
    next_cycle(); hz.ex_mem_read = 1; hz.ex_WREG = 1; hz.id_use_rs = 1; #1;
    chk("lu_r0_pc_en", hz.pc_en, 1);
    // rt path
    next_cycle(); hz.ex_td = 9; hz.ex_mem_read = 1; hz.ex_WREG = 1;
    hz.id_rt = 9; hz.id_use_rt = 1; hz.id_rs = 9; #1;
    chk("lu_rt_pc_en", hz.pc_en, 0);

    // forwarding
    next_cycle(); hz.me_td = 3; hz.me_WREG = 1; hz.wb_td = 3; hz.wb_WREG = 1;
    hz.ex_rs = 3; hz.ex_rt = 3; #1;
    chk("fwd_a_me", hz.fwd_a, 2'b01);
    chk("fwd_b_me", hz.fwd_b, 2'b01);
    next_cycle(); hz.me_td = 3; hz.wb_td = 3; hz.wb_WREG = 1; hz.ex_rs = 3; hz.ex_rt = 4; #1;
    chk("fwd_a_wb", hz.fwd_a, 2'b10);
    chk("fwd_b_none", hz.fwd_b, 2'b00);
    next_cycle(); hz.me_WREG = 1; hz.wb_WREG = 1; #1;
    chk("fwd_a_r0", hz.fwd_a, 2'b00);

    // memory wait: 3 not-ready cycles, then ready on the timeout cycle itself
    for (int i = 0; i < 3; i++) begin
      next_cycle(); hz.me_mem_access = 1; #1;
      chk("mw_pc_en",      hz.pc_en,      0);
      chk("mw_mewb_flush", hz.mewb_flush, 1);
      chk("mw_stall_cnt",  hz.stall_cnt,  2 + i);
    end
    next_cycle(); hz.me_mem_access = 1; hz.dmem_ready = 1; #1;
    chk("mw_rel_pc_en", hz.pc_en, 1);
    next_cycle(); #1;
    chk("mw_mem_err",   hz.mem_err,   0);
    chk("mw_stall_cnt_end", hz.stall_cnt, 5);

    // back-to-back accesses
    next_cycle(); hz.me_mem_access = 1; hz.dmem_ready = 1; #1;
    chk("b2b_ready_pc_en", hz.pc_en, 1);
    next_cycle(); hz.me_mem_access = 1; #1;
    next_cycle(); hz.me_mem_access = 1; hz.dmem_ready = 1; #1;
    next_cycle(); hz.me_mem_access = 1; #1;
    chk("b2b_restart_pc_en", hz.pc_en, 0);
    next_cycle(); hz.me_mem_access = 1; hz.dmem_ready = 1; #1;

    // timeout
    for (int i = 0; i < 4; i++) begin
      next_cycle(); hz.me_mem_access = 1; #1;
      chk("to_pc_en", hz.pc_en, (i == 3) ? 1 : 0);
      chk("to_err_pre", hz.mem_err, 0);
    end
    next_cycle(); #1;
    chk("to_mem_err", hz.mem_err, 1);
    next_cycle(); #1;
    chk("to_mem_err_held", hz.mem_err, 1);

    // priority: branch over load-use
    next_cycle(); set_lu(); hz.ex_branch_taken = 1; #1;
    chk("pri_br_ifid_flush", hz.ifid_flush, 1);
    chk("pri_br_idex_flush", hz.idex_flush, 1);
    chk("pri_br_pc_en",      hz.pc_en,      1);
    // memory stall over branch, branch applied on release
    for (int i = 0; i < 2; i++) begin
      next_cycle(); set_lu(); hz.ex_branch_taken = 1; hz.me_mem_access = 1; #1;
      chk("pri_ms_pc_en",      hz.pc_en,      0);
      chk("pri_ms_ifid_flush", hz.ifid_flush, 0);
      chk("pri_ms_idex_flush", hz.idex_flush, 0);
    end
    next_cycle(); set_lu(); hz.ex_branch_taken = 1; hz.me_mem_access = 1; hz.dmem_ready = 1; #1;
    chk("pri_rel_ifid_flush", hz.ifid_flush, 1);
    chk("pri_rel_pc_en",      hz.pc_en,      1);

    // saturation of the stall counter
    for (int i = 0; i < 20; i++) begin
      next_cycle(); set_lu();
    end
    next_cycle(); #1;
    chk("sat_stall_cnt", hz.stall_cnt, CMAX);

    // reset in the middle of a wait
    next_cycle(); hz.me_mem_access = 1;
    next_cycle(); hz.me_mem_access = 1;
    rst = 1'b1; #1;
    chk("rstw_stall_cnt", hz.stall_cnt, 0);
    chk("rstw_mem_err",   hz.mem_err,   0);
    next_cycle(); hz.me_mem_access = 1;
    rst = 1'b0;
    // fresh wait from RUN: forced release only on the 4th cycle of the access
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin
        next_cycle(); hz.me_mem_access = 1;
      end
      #1;
      chk("rstw_to_pc_en", hz.pc_en, (i == 3) ? 1 : 0);
    end
    next_cycle(); #1;
    chk("rstw_to_err", hz.mem_err, 1);
    next_cycle();
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the enable and flush inputs of the IF_ID, ID_EX, EX_ME and ME_WB pipeline registers and the PC, and selects EX-stage operand forwarding. It detects load-use hazards, flushes on taken branches, and freezes the front of the pipe while the data memory is not ready. Memory waits are bounded by a timeout, and a saturating stall-cycle counter is kept.

## Interface

- MEM_TIMEOUT, 16, max cycles a single ME-stage access may wait before forced release (≥2)
- CNT_W, 16, stall counter width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- ex_rs, ex_rt  in  5 each  source registers of the instruction in EX
- ex_td  in  5  destination register in EX
- ex_WREG, ex_mem_read  in  1 each  EX writes a register / is a load
- ex_branch_taken  in  1  branch resolved taken in EX
- me_td, me_WREG  in  5, 1  ME-stage destination / write enable
- me_mem_access  in  1  ME instruction is a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- wb_td, wb_WREG  in  5, 1  WB-stage destination / write enable
- pc_en, ifid_en, idex_en, exme_en, mewb_en  out  1 each  register load enables
- ifid_flush, idex_flush, mewb_flush  out  1 each  load a bubble (all fields zero) instead of data
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 EX_ME result, 10 ME_WB result
- dmem_req  out  1  = me_mem_access
- mem_err  out  1  sticky, set on timeout
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

## Operation

- FSM states: RUN, MEM_WAIT. A timeout counter wait_cnt is kept (width log2 of MEM_TIMEOUT, rounded up).
- Release: release = dmem_ready, or (state==MEM_WAIT and wait_cnt==MEM_TIMEOUT-1).
- Memory stall: mem_stall = me_mem_access & ~release.
- RUN transitions: if mem_stall, go to MEM_WAIT with wait_cnt←1.
- MEM_WAIT transitions: if release, go to RUN and wait_cnt←0. If the release was a timeout, also set mem_err←1. Otherwise wait_cnt++.
- Load-use hazard: lu = ex_mem_read & ex_WREG & ex_td≠0 & ((id_use_rs & id_rs==ex_td) | (id_use_rt & id_rt==ex_td)).
- Stall/flush priority, highest first:
  - mem_stall: pc/ifid/idex/exme enables 0, mewb_en=1, mewb_flush=1 (bubble into WB). Branch and load-use responses are deferred, since their inputs are held.
  - ex_branch_taken: all enables 1, ifid_flush=1, idex_flush=1. Load-use is ignored because the ID instruction is squashed.
  - lu: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exme_en=mewb_en=1.
  - otherwise: all enables 1, all flushes 0.
- Forwarding for fwd_a (rs) and fwd_b (rt), same rule for each:
  - 01 if me_WREG & me_td≠0 & me_td==ex_rs/rt.
  - else 10 if wb_WREG & wb_td≠0 & wb_td==ex_rs/rt.
  - else 00.
  - ME takes priority over WB.
- stall_cnt increments every cycle that pc_en=0 and saturates at all-ones.

## Timing

- Enables, flushes, fwd_* and dmem_req are combinational from the current inputs and state. They are sampled by the pipeline registers on the same rising edge.
- Reset (async): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0. Outputs then follow the rules above with state=RUN.
- Load-use costs exactly 1 bubble. On the next cycle the load is in ME and lu drops.
- Memory wait: the stall lasts from the first cycle with me_mem_access&~dmem_ready up to and including the cycle before release. The advance happens on the release cycle.
- Timeout: at most MEM_TIMEOUT cycles in the access. The forced release cycle advances the pipe and mem_err rises on that edge.
- dmem_ready asserted in the same cycle as the timeout: treated as a normal release, mem_err is not set.
- Back-to-back memory accesses: a new access entering ME right after a release starts from RUN with wait_cnt=0.
- rst mid-wait: returns to RUN immediately and clears mem_err and the counters.

## Test plan

- Load-use: lw r5 in EX (ex_td=5, ex_mem_read=1), id_rs=5, id_use_rs=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1. Next cycle all enables 1. stall_cnt=1.
- Forwarding: me_td=3 with me_WREG, and wb_td=3 with wb_WREG, ex_rs=3 -> fwd_a=01. Drop me_WREG -> fwd_a=10. With td=0 -> fwd_a=00.
- Memory wait: me_mem_access=1, dmem_ready low 3 cycles then high -> 3 stall cycles with mewb_flush=1, advance on cycle 4. state returns to RUN, mem_err=0.
- Timeout: MEM_TIMEOUT=4, dmem_ready never asserted -> 3 stall cycles, forced advance on cycle 4, mem_err=1 and held.
- Priority: ex_branch_taken=1 together with lu -> ifid_flush=idex_flush=1, pc_en=1. Same inputs with mem_stall active -> front frozen, no flushes until release.
- Reset mid-MEM_WAIT: assert rst for 1 cycle -> state RUN, stall_cnt=0, mem_err=0 immediately.
